// File: rtl/mod_mult_serial_pkg.sv
// Shared types and default parameters for the bit-serial modular multiplier.
package mod_mult_serial_pkg;

    localparam int unsigned DEF_DATAWIDTH = 8;
    localparam int unsigned DEF_P         = 251;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : mod_mult_serial_pkg

// File: rtl/mod_mult_serial_dbl_add.sv
// One interleaved iteration: next = ((2*acc mod P) + (bit ? ra : 0)) mod P.
module mod_dbl_add #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned P         = 251
) (
    input  logic [DATAWIDTH-1:0] acc_i,
    input  logic [DATAWIDTH-1:0] ra_i,
    input  logic                 bit_i,
    output logic [DATAWIDTH-1:0] acc_nxt_c
);

    localparam int unsigned W1 = DATAWIDTH + 1;
    localparam logic [W1-1:0] P_EXT = W1'(P);

    logic [W1-1:0] dbl_c;
    logic [W1-1:0] dbl_red_c;
    logic [W1-1:0] sum_c;
    logic [W1-1:0] sum_red_c;

    // Double, reduce, conditionally add the multiplicand, reduce again.
    // Both inputs stay below P, so one subtraction per stage suffices.
    always_comb begin
        dbl_c     = {acc_i, 1'b0};
        dbl_red_c = (dbl_c >= P_EXT) ? (dbl_c - P_EXT) : dbl_c;
        sum_c     = bit_i ? (dbl_red_c + {1'b0, ra_i}) : dbl_red_c;
        sum_red_c = (sum_c >= P_EXT) ? (sum_c - P_EXT) : sum_c;
        acc_nxt_c = DATAWIDTH'(sum_red_c);
    end

endmodule : mod_dbl_add

// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: product = (a * b) mod P.
module mod_mult_serial
    import mod_mult_serial_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned P         = DEF_P
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] product,
    output logic                 outReady,
    output logic                 busy
);

    localparam int unsigned CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [DATAWIDTH-1:0] P_W = DATAWIDTH'(P);

    state_e               st_q, st_d;
    logic [DATAWIDTH-1:0] ra_q, ra_d;
    logic [DATAWIDTH-1:0] rb_q, rb_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] product_q, product_d;
    logic                 out_ready_q, out_ready_d;
    logic                 busy_q, busy_d;

    logic                 bit_c;
    logic [DATAWIDTH-1:0] acc_step_c;

    // Multiplier bit for the current iteration, MSB first.
    always_comb begin
        bit_c = rb_q[cnt_q];
    end

    mod_dbl_add #(
        .DATAWIDTH (DATAWIDTH),
        .P         (P)
    ) u_dbl_add (
        .acc_i     (acc_q),
        .ra_i      (ra_q),
        .bit_i     (bit_c),
        .acc_nxt_c (acc_step_c)
    );

    // Next-state and datapath control.
    always_comb begin
        st_d        = st_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_ready_d = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (enable) begin
                    ra_d  = (a >= P_W) ? (a - P_W) : a;
                    rb_d  = b;
                    acc_d = '0;
                    cnt_d = CW'(DATAWIDTH - 1);
                    st_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_step_c;
                if (cnt_q == '0) begin
                    st_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                product_d   = acc_q;
                out_ready_d = 1'b1;
                st_d        = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        busy_d = (st_d == ST_RUN) || (st_d == ST_DONE);
    end

    // State, operand and output registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_ready_q <= out_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign product  = product_q;
    assign outReady = out_ready_q;
    assign busy     = busy_q;

endmodule : mod_mult_serial

// File: tb/tb_mod_mult_serial.sv
// Directed bench: small field (5 bits, P=23) and default field instances.
module tb_mod_mult_serial;
    import mod_mult_serial_pkg::*;

    localparam int unsigned SW = 5;
    localparam int unsigned SP = 23;
    localparam int unsigned DW = DEF_DATAWIDTH;
    localparam int unsigned DP = DEF_P;

    logic          clk;
    logic          rst_n;
    logic          en_s, en_d;
    logic [SW-1:0] a_s, b_s, product_s;
    logic [DW-1:0] a_d, b_d, product_d;
    logic          rdy_s, rdy_d, busy_s, busy_d;

    int errors = 0;
    int checks = 0;

    mod_mult_serial #(.DATAWIDTH(SW), .P(SP)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (en_s),
        .a        (a_s),
        .b        (b_s),
        .product  (product_s),
        .outReady (rdy_s),
        .busy     (busy_s)
    );

    mod_mult_serial dut_d (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (en_d),
        .a        (a_d),
        .b        (b_d),
        .product  (product_d),
        .outReady (rdy_d),
        .busy     (busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int prod_of(input bit dflt);
        return dflt ? int'(product_d) : int'(product_s);
    endfunction

    function automatic bit rdy_of(input bit dflt);
        return dflt ? rdy_d : rdy_s;
    endfunction

    function automatic bit busy_of(input bit dflt);
        return dflt ? busy_d : busy_s;
    endfunction

    // One enable pulse; checks latency, busy duration, product and pulse width.
    task automatic do_op(input bit dflt, input int av, input int bv, input int exp, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        int w;
        w = dflt ? int'(DW) : int'(SW);
        @(negedge clk);
        if (dflt) begin a_d = DW'(av); b_d = DW'(bv); en_d = 1'b1; end
        else      begin a_s = SW'(av); b_s = SW'(bv); en_s = 1'b1; end
        @(posedge clk); #1;
        busy_cnt = busy_of(dflt) ? 1 : 0;
        @(negedge clk);
        en_s = 1'b0; en_d = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_of(dflt)) busy_cnt++;
            if (rdy_of(dflt)) seen = 1'b1;
        end
        chk({tag, "_lat"}, lat, w + 1);
        chk({tag, "_busy"}, busy_cnt, w + 1);
        chk({tag, "_prod"}, prod_of(dflt), exp);
        @(posedge clk); #1;
        chk({tag, "_rdy_low"}, int'(rdy_of(dflt)), 0);
        chk({tag, "_hold"}, prod_of(dflt), exp);
    endtask

    initial begin
        int pulses;
        int e1, e2, p1, p2;
        int x, inv;

        rst_n = 1'b0;
        en_s = 1'b0; en_d = 1'b0;
        a_s = '0; b_s = '0; a_d = '0; b_d = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod_s", int'(product_s), 0);
        chk("rst_rdy_s",  int'(rdy_s), 0);
        chk("rst_busy_s", int'(busy_s), 0);
        chk("rst_prod_d", int'(product_d), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: 7*10 mod 23.
        do_op(1'b0, 7, 10, 1, "t1");

        // Test 2: boundary operands.
        do_op(1'b0, 22, 22, 1, "t2_max");
        do_op(1'b0, 0, 17, 0, "t2_azero");
        do_op(1'b0, 23, 5, 0, "t2_aeqp");
        do_op(1'b0, 9, 0, 0, "t2_bzero");

        // Test 3: enable re-pulsed while busy with different inputs.
        @(negedge clk);
        a_s = 5'd3; b_s = 5'd4; en_s = 1'b1;
        @(posedge clk);
        @(negedge clk); en_s = 1'b0; a_s = 5'd7; b_s = 5'd9;
        @(posedge clk);
        @(negedge clk); en_s = 1'b1;
        @(posedge clk);
        @(negedge clk); en_s = 1'b0;
        @(posedge clk);
        @(negedge clk); en_s = 1'b1;
        @(posedge clk);
        @(negedge clk); en_s = 1'b0;
        pulses = 0;
        for (int e = 5; e <= 16; e++) begin
            @(posedge clk); #1;
            if (rdy_s) begin
                pulses++;
                chk("t3_prod", int'(product_s), 12);
            end
        end
        chk("t3_pulses", pulses, 1);

        // Test 4: enable held high, inputs switched after first capture.
        @(negedge clk);
        a_s = 5'd5; b_s = 5'd9; en_s = 1'b1;
        @(posedge clk);
        @(negedge clk); a_s = 5'd6; b_s = 5'd4;
        pulses = 0; e1 = -1; e2 = -1; p1 = -1; p2 = -1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            if (rdy_s) begin
                pulses++;
                if (pulses == 1) begin e1 = e; p1 = int'(product_s); end
                else if (pulses == 2) begin e2 = e; p2 = int'(product_s); end
            end
            if (e == 7) begin
                @(negedge clk);
                en_s = 1'b0;
            end
        end
        chk("t4_first_edge", e1, 6);
        chk("t4_first_prod", p1, 22);
        chk("t4_spacing", e2 - e1, 7);
        chk("t4_second_prod", p2, 1);
        chk("t4_pulses", pulses, 2);

        // Test 5: reset mid-run.
        @(negedge clk);
        a_s = 5'd11; b_s = 5'd13; en_s = 1'b1;
        @(posedge clk);
        @(negedge clk); en_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_prod", int'(product_s), 0);
        chk("t5_rdy",  int'(rdy_s), 0);
        chk("t5_busy", int'(busy_s), 0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rdy_s) pulses++;
        end
        chk("t5_no_rdy", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 2, 12, 1, "t5_after");

        // Test 6: default field; x times its inverse is one.
        for (int i = 0; i < 3; i++) begin
            x = int'($urandom_range(DP - 1, 1));
            inv = 0;
            for (int k = 1; k < int'(DP); k++) begin
                if (((x * k) % int'(DP)) == 1) inv = k;
            end
            do_op(1'b1, x, inv, 1, "t6_inv");
        end
        do_op(1'b1, 1, 200, 200, "t6_one");
        do_op(1'b1, 250, 250, 1, "t6_neg1sq");
        do_op(1'b1, 254, 2, 6, "t6_ared");
        do_op(1'b1, 251, 77, 0, "t6_aeqp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mod_mult_serial
